nvm_spike_out_writer: RTL and testbench
=======================================

Name: nvm_spike_out_writer

Overview:
- Upstream stage of the spike-out Wishbone store: collects one timestep's output-neuron spikes (64 neurons, one bit per beat) from the neuron array.
- Packs the spikes into 16 nibbles and writes them, as a Wishbone master, into the spike-out store at consecutive word addresses, one nibble per transaction.
- Reports frame completion, a frame counter and a sticky ack-timeout error to control logic.

Parameters:
- NUM_NEURONS, 64, spikes per frame; must be a multiple of 4, max 64.
- BASE_ADDR, 32'h0000_0000, address of nibble 0 in the spike-out store; nibble k goes to BASE_ADDR+k.
- ACK_TIMEOUT, 255, max cycles waiting for wbm_ack_i per transaction (8-bit counter).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- spike_valid_i  in  1  spike beat valid.
- spike_i  in  1  spike bit of current neuron (neuron index = beats accepted so far in frame).
- spike_last_i  in  1  marks final beat of frame; may arrive early.
- spike_ready_o  out  1  beat accepted when valid&ready at rising edge.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe; always equal to wbm_cyc_o.
- wbm_we_o  out  1  write enable; 1 whenever cyc is 1.
- wbm_sel_o  out  4  byte select; 4'b0001 whenever cyc is 1, else 0.
- wbm_adr_o  out  32  BASE_ADDR+k during transaction k, else 0.
- wbm_dat_o  out  32  {28'b0, nibble k} during transaction k, else 0.
- wbm_ack_i  in  1  slave acknowledge (registered slave, stays high while cyc&stb).
- busy_o  out  1  high in WRITE/GAP.
- frame_done_o  out  1  one-cycle pulse after the last nibble is acked.
- frame_cnt_o  out  16  completed frames; wraps 16'hFFFF->0.
- err_timeout_o  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (async, wb_rst_ni=0): state COLLECT, spike buffer=0, beat count=0, nibble index=0, timeout counter=0. All wbm_* outputs 0, spike_ready_o=1, busy_o=0, frame_done_o=0, frame_cnt_o=0, err_timeout_o=0. Asserting reset mid-transaction drops cyc/stb immediately and discards the frame.
- State COLLECT:
  - spike_ready_o=1.
  - On each accepted beat, buffer[count]<=spike_i and count++.
  - Transition to WRITE with k=0 after the accepted beat where count reaches NUM_NEURONS-1, or on an accepted beat with spike_last_i=1.
  - Unreceived neurons read as 0. The buffer is cleared at frame start.
  - Beats arriving after NUM_NEURONS without last: never possible, since the FSM leaves COLLECT.
- State WRITE:
  - cyc=stb=we=1, sel=0001, adr=BASE_ADDR+k, dat={28'b0, buffer[4k+3:4k]}; spike_ready_o=0.
  - Outputs are registered and stable for the whole transaction.
  - On wbm_ack_i=1, go to GAP.
  - The timeout counter increments each WRITE cycle without ack. When it reaches ACK_TIMEOUT: set err_timeout_o, drop cyc/stb, clear buffer/count, return to COLLECT. No frame_done_o, frame_cnt_o unchanged.
- State GAP (exactly 1 cycle):
  - cyc=stb=0; wbm_ack_i ignored (the slave's ack lags by one cycle); timeout counter cleared.
  - If k=NUM_NEURONS/4-1: go to COLLECT, pulse frame_done_o, frame_cnt_o++, clear buffer/count.
  - Else k++ and go to WRITE.
- Timing:
  - With an ack on the first possible edge, each nibble costs 3 cycles: WRITE request, WRITE ack-seen, GAP.
  - A 64-neuron frame flushes in 48 cycles from COLLECT exit to the frame_done_o pulse.
  - The next beat is accepted on the cycle after frame_done_o.
- Simultaneous events: spike_valid_i during WRITE/GAP is held off (ready=0); the upstream must hold the beat. An ack arriving on the same edge as the timeout threshold counts as a success (ack has priority).
- Nibble bit order: neuron 4k+j maps to wbm_dat_o[j].

Test Plan:
- 64 beats with spike_i=1 only on neurons 0,5,63, slave responds normally -> 16 writes: adr 0 dat 0x1, adr 1 dat 0x2, adr 15 dat 0x8, others 0x0; frame_done_o pulses once, 48 cycles after the last beat; frame_cnt_o=1.
- spike_last_i on beat 9 with neurons 8,9 set -> 16 writes still issued; adr 2 dat 0x3, adrs 3..15 dat 0x0.
- Slave stalls ack 10 cycles on nibble 4 -> wbm_adr_o/dat_o stable throughout, no timeout, total frame time 58 cycles.
- Slave never acks -> after 255 WRITE cycles err_timeout_o=1, cyc=0, no frame_done_o; next 64-beat frame completes normally with err_timeout_o still 1.
- spike_valid_i held high through flush -> no beats lost or duplicated; back-to-back frames give frame_cnt_o=2 and correct data per frame.
- wb_rst_ni low mid-WRITE (k=7) -> cyc/stb 0 combinationally with reset; after release, all outputs at reset values and a new frame starts from neuron 0.

Source files
------------

// File: rtl/nvm_spike_out_writer.sv
// nvm_spike_out_writer: gathers one timestep of output-neuron spikes and
// writes them as nibbles, one Wishbone write per nibble, into the spike-out
// store. Reports frame completion, a frame counter and a sticky ack-timeout.
module nvm_spike_out_writer #(
    parameter int unsigned NUM_NEURONS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        spike_valid_i,
    input  logic        spike_i,
    input  logic        spike_last_i,
    output logic        spike_ready_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o,
    output logic        err_timeout_o
);

    localparam int unsigned NIB = NUM_NEURONS / 4;
    localparam int unsigned CW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_WRITE,
        S_GAP
    } state_e;

    state_e                 state_q;
    logic [NUM_NEURONS-1:0] buf_q;
    logic [NUM_NEURONS-1:0] buf_ins;
    logic [CW-1:0]          cnt_q;
    logic [KW-1:0]          k_q;
    logic [KW-1:0]          k_inc;
    logic [7:0]             tmo_q;
    logic                   cyc_q;
    logic [31:0]            adr_q;
    logic [3:0]             nib_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic [15:0]            fcnt_q;
    logic                   err_q;
    logic                   beat_acc;
    logic                   frame_end;

    // Neuron 4k+j lands on data bit j of transaction k.
    function automatic logic [3:0] nib_of(input logic [NUM_NEURONS-1:0] b,
                                          input logic [KW-1:0] k);
        return b[4*int'(k) +: 4];
    endfunction

    // Beat acceptance and the buffer image including the beat being accepted,
    // so nibble 0 can be loaded on the same edge the frame closes.
    always_comb begin
        beat_acc  = spike_valid_i && ready_q;
        frame_end = spike_last_i || (cnt_q == CW'(NUM_NEURONS - 1));
        k_inc     = k_q + KW'(1);
        buf_ins   = buf_q;
        if (beat_acc) begin
            buf_ins[cnt_q] = spike_i;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_COLLECT;
            buf_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            nib_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_COLLECT: begin
                    if (beat_acc) begin
                        buf_q <= buf_ins;
                        if (frame_end) begin
                            state_q <= S_WRITE;
                            cnt_q   <= '0;
                            k_q     <= '0;
                            tmo_q   <= '0;
                            cyc_q   <= 1'b1;
                            adr_q   <= BASE_ADDR;
                            nib_q   <= nib_of(buf_ins, '0);
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    // Ack wins over a timeout reached on the same edge.
                    if (wbm_ack_i) begin
                        state_q <= S_GAP;
                        cyc_q   <= 1'b0;
                        adr_q   <= '0;
                        nib_q   <= '0;
                        tmo_q   <= '0;
                    end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
                        state_q <= S_COLLECT;
                        err_q   <= 1'b1;
                        cyc_q   <= 1'b0;
                        adr_q   <= '0;
                        nib_q   <= '0;
                        tmo_q   <= '0;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        k_q     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_GAP: begin
                    tmo_q <= '0;
                    if (k_q == KW'(NIB - 1)) begin
                        state_q <= S_COLLECT;
                        done_q  <= 1'b1;
                        fcnt_q  <= fcnt_q + 16'd1;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        k_q     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WRITE;
                        k_q     <= k_inc;
                        cyc_q   <= 1'b1;
                        adr_q   <= BASE_ADDR + 32'(k_inc);
                        nib_q   <= nib_of(buf_q, k_inc);
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                    cyc_q   <= 1'b0;
                    adr_q   <= '0;
                    nib_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign spike_ready_o = ready_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = cyc_q;
    assign wbm_sel_o     = {3'b000, cyc_q};
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = {28'b0, nib_q};
    assign busy_o        = busy_q;
    assign frame_done_o  = done_q;
    assign frame_cnt_o   = fcnt_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_nvm_spike_out_writer.sv
// Directed bench for nvm_spike_out_writer with a registered Wishbone slave.
`timescale 1ns/1ps
module tb_nvm_spike_out_writer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        spike_valid_i = 1'b0;
    logic        spike_i = 1'b0;
    logic        spike_last_i = 1'b0;
    logic        spike_ready_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic        busy_o;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;
    logic        err_timeout_o;

    int unsigned total = 0;
    int unsigned bad = 0;

    // slave configuration (written by tests only)
    bit          no_ack = 1'b0;
    logic [31:0] stall_adr = 32'hFFFF_FFFF;
    int unsigned stall_len = 0;

    // slave/monitor state (written by monitors only)
    int unsigned wait_c = 0;
    logic [31:0] log_adr [256];
    logic [31:0] log_dat [256];
    int unsigned log_n = 0;
    int unsigned viol = 0;
    int unsigned unstable = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [31:0] prev_dat = '0;
    int unsigned done_cnt = 0;
    time         done_t = 0;

    // driver state
    int unsigned beats_acc = 0;
    time         last_acc_t = 0;

    nvm_spike_out_writer dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .spike_valid_i (spike_valid_i),
        .spike_i       (spike_i),
        .spike_last_i  (spike_last_i),
        .spike_ready_o (spike_ready_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_dat_o     (wbm_dat_o),
        .wbm_ack_i     (wbm_ack_i),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .frame_cnt_o   (frame_cnt_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Registered slave: logs writes, counts bus-rule violations, holds ack.
    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && log_n < 256) begin
            log_adr[log_n] <= wbm_adr_o;
            log_dat[log_n] <= wbm_dat_o;
            log_n          <= log_n + 1;
        end
        if ((wbm_stb_o !== wbm_cyc_o) ||
            (wbm_cyc_o === 1'b1 && (wbm_we_o !== 1'b1 || wbm_sel_o !== 4'b0001 || wbm_dat_o[31:4] !== 28'h0)) ||
            (wbm_cyc_o !== 1'b1 && (wbm_we_o !== 1'b0 || wbm_sel_o !== 4'b0000 ||
                                    wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0)))
            viol <= viol + 1;
        if (wbm_cyc_o && prev_cyc && (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat))
            unstable <= unstable + 1;
        prev_cyc <= wbm_cyc_o;
        prev_adr <= wbm_adr_o;
        prev_dat <= wbm_dat_o;
        if (!wbm_cyc_o) begin
            wbm_ack_i <= 1'b0;
            wait_c    <= 0;
        end else if (no_ack) begin
            wbm_ack_i <= 1'b0;
        end else if (wbm_adr_o == stall_adr && wait_c < stall_len) begin
            wait_c    <= wait_c + 1;
            wbm_ack_i <= 1'b0;
        end else begin
            wbm_ack_i <= 1'b1;
        end
    end

    // Frame-done pulse counter; records the rising edge that raised it.
    always @(negedge wb_clk_i) begin
        if (frame_done_o === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_t   <= $time - 5;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic send_frame(input logic [63:0] bits, input int unsigned nb,
                              input bit hold, output bit ok);
        bit          acc;
        int unsigned w;
        ok = 1'b1;
        for (int unsigned i = 0; i < nb; i++) begin
            @(negedge wb_clk_i);
            spike_valid_i = 1'b1;
            spike_i       = bits[i];
            spike_last_i  = (i == nb - 1);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 1000) begin
                acc = spike_ready_o;
                @(posedge wb_clk_i);
                if (!acc) begin
                    w++;
                    @(negedge wb_clk_i);
                end
            end
            if (!acc) begin
                ok = 1'b0;
                break;
            end
            beats_acc++;
            last_acc_t = $time;
        end
        if (!hold || !ok) begin
            @(negedge wb_clk_i);
            spike_valid_i = 1'b0;
            spike_last_i  = 1'b0;
            spike_i       = 1'b0;
        end
    endtask

    task automatic wait_done(input int unsigned target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge wb_clk_i);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge wb_clk_i);
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        total++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000 || wbm_sel_o !== 4'h0) begin
            bad++;
            $display("FAIL reset_ctrl: cyc/stb/we=%b%b%b sel=%h, want 000 sel=0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o);
        end
        total++;
        if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_bus: adr=%h dat=%h, want 0 0", wbm_adr_o, wbm_dat_o);
        end
        total++;
        if (spike_ready_o !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: ready=%b busy=%b done=%b, want 1 0 0",
                     spike_ready_o, busy_o, frame_done_o);
        end
        total++;
        if (frame_cnt_o !== 16'h0 || err_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_cnt: fcnt=%0d err=%b, want 0 0", frame_cnt_o, err_timeout_o);
        end
        wb_rst_ni = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        total++;
        if (spike_ready_o !== 1'b1 || busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b cyc=%b, want 1 0 0",
                     spike_ready_o, busy_o, wbm_cyc_o);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_img;
        int unsigned n0, d0, v0;
        bit          ok;
        time         dt;
        exp_img = 64'h8000_0000_0000_0021;   // neurons 0,5,63
        n0 = log_n; d0 = done_cnt; v0 = viol;
        send_frame(64'h8000_0000_0000_0021, 64, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_send: beats accepted=%b, want 1", ok); end
        total++;
        if (busy_o !== 1'b1 || spike_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: busy=%b ready=%b, want 1 0", busy_o, spike_ready_o);
        end
        wait_done(d0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done_wait: done seen=%b, want 1", ok); end
        total++;
        if (log_n - n0 != 16) begin
            bad++;
            $display("FAIL basic_nwrites: got %0d, want 16", log_n - n0);
        end else begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (log_adr[n0 + k] !== 32'(k) || log_dat[n0 + k] !== {28'h0, exp_img[4*k +: 4]}) begin
                    bad++;
                    $display("FAIL basic_write%0d: adr=%h dat=%h, want adr=%h dat=%h", k,
                             log_adr[n0 + k], log_dat[n0 + k], k, exp_img[4*k +: 4]);
                end
            end
        end
        dt = done_t - last_acc_t;
        total++;
        if (done_cnt - d0 != 1 || dt != 480) begin
            bad++;
            $display("FAIL basic_timing: pulses=%0d cycles=%0d, want 1 48", done_cnt - d0, dt / 10);
        end
        total++;
        if (frame_cnt_o !== 16'd1 || viol != v0) begin
            bad++;
            $display("FAIL basic_fcnt: fcnt=%0d busviol=%0d, want 1 0", frame_cnt_o, viol - v0);
        end
        total++;
        if (spike_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: ready=%b busy=%b, want 1 0", spike_ready_o, busy_o);
        end
    endtask

    task automatic test_early_last();
        logic [63:0] exp_img;
        int unsigned n0, d0;
        bit          ok;
        time         dt;
        exp_img = 64'h0000_0000_0000_0300;   // neurons 8,9 -> nibble 2 = 3
        n0 = log_n; d0 = done_cnt;
        send_frame(64'h0000_0000_0000_0300, 10, 1'b0, ok);
        wait_done(d0 + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL early_done_wait: done seen=%b, want 1", ok); end
        total++;
        if (log_n - n0 != 16) begin
            bad++;
            $display("FAIL early_nwrites: got %0d, want 16", log_n - n0);
        end else begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (log_adr[n0 + k] !== 32'(k) || log_dat[n0 + k] !== {28'h0, exp_img[4*k +: 4]}) begin
                    bad++;
                    $display("FAIL early_write%0d: adr=%h dat=%h, want adr=%h dat=%h", k,
                             log_adr[n0 + k], log_dat[n0 + k], k, exp_img[4*k +: 4]);
                end
            end
        end
        dt = done_t - last_acc_t;
        total++;
        if (dt != 480 || frame_cnt_o !== 16'd2) begin
            bad++;
            $display("FAIL early_fcnt: cycles=%0d fcnt=%0d, want 48 2", dt / 10, frame_cnt_o);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp_img;
        int unsigned n0, d0, u0;
        bit          ok;
        time         dt;
        exp_img = 64'h0123_4567_89AB_CDEF;
        n0 = log_n; d0 = done_cnt; u0 = unstable;
        stall_adr = 32'd4;
        stall_len = 10;
        send_frame(64'h0123_4567_89AB_CDEF, 64, 1'b0, ok);
        wait_done(d0 + 1, ok);
        stall_adr = 32'hFFFF_FFFF;
        stall_len = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL stall_done_wait: done seen=%b, want 1", ok); end
        dt = done_t - last_acc_t;
        total++;
        if (dt != 580) begin
            bad++;
            $display("FAIL stall_timing: cycles=%0d, want 58", dt / 10);
        end
        total++;
        if (unstable != u0 || err_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_stable: changes=%0d err=%b, want 0 0", unstable - u0, err_timeout_o);
        end
        total++;
        if (log_n - n0 != 16) begin
            bad++;
            $display("FAIL stall_nwrites: got %0d, want 16", log_n - n0);
        end else begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (log_adr[n0 + k] !== 32'(k) || log_dat[n0 + k] !== {28'h0, exp_img[4*k +: 4]}) begin
                    bad++;
                    $display("FAIL stall_write%0d: adr=%h dat=%h, want adr=%h dat=%h", k,
                             log_adr[n0 + k], log_dat[n0 + k], k, exp_img[4*k +: 4]);
                end
            end
        end
        total++;
        if (frame_cnt_o !== 16'd3) begin
            bad++;
            $display("FAIL stall_fcnt: got %0d, want 3", frame_cnt_o);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] exp_img;
        int unsigned n0, d0;
        bit          ok;
        d0 = done_cnt;
        no_ack = 1'b1;
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, ok);
        repeat (254) @(negedge wb_clk_i);
        total++;
        if (wbm_cyc_o !== 1'b1 || err_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL tmo_before: cyc=%b err=%b after 254 cycles, want 1 0", wbm_cyc_o, err_timeout_o);
        end
        @(negedge wb_clk_i);
        total++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || err_timeout_o !== 1'b1) begin
            bad++;
            $display("FAIL tmo_at: cyc=%b stb=%b err=%b after 255 cycles, want 0 0 1",
                     wbm_cyc_o, wbm_stb_o, err_timeout_o);
        end
        total++;
        if (spike_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL tmo_idle: ready=%b busy=%b, want 1 0", spike_ready_o, busy_o);
        end
        repeat (3) @(negedge wb_clk_i);
        total++;
        if (done_cnt != d0 || frame_cnt_o !== 16'd3) begin
            bad++;
            $display("FAIL tmo_nodone: pulses=%0d fcnt=%0d, want 0 3", done_cnt - d0, frame_cnt_o);
        end
        no_ack = 1'b0;
        exp_img = 64'h0000_0000_0000_F00F;
        n0 = log_n;
        send_frame(64'h0000_0000_0000_F00F, 64, 1'b0, ok);
        wait_done(d0 + 1, ok);
        total++;
        if (!ok || frame_cnt_o !== 16'd4 || err_timeout_o !== 1'b1) begin
            bad++;
            $display("FAIL tmo_recover: done=%b fcnt=%0d err=%b, want 1 4 1", ok, frame_cnt_o, err_timeout_o);
        end
        total++;
        if (log_n - n0 != 16) begin
            bad++;
            $display("FAIL tmo_nwrites: got %0d, want 16", log_n - n0);
        end else begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (log_adr[n0 + k] !== 32'(k) || log_dat[n0 + k] !== {28'h0, exp_img[4*k +: 4]}) begin
                    bad++;
                    $display("FAIL tmo_write%0d: adr=%h dat=%h, want adr=%h dat=%h", k,
                             log_adr[n0 + k], log_dat[n0 + k], k, exp_img[4*k +: 4]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned d0;
        bit          ok;
        bit          found;
        d0 = done_cnt;
        send_frame(64'hAAAA_AAAA_AAAA_AAAA, 64, 1'b0, ok);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wbm_cyc_o === 1'b1 && wbm_adr_o === 32'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge wb_clk_i);
        end
        total++;
        if (!found) begin bad++; $display("FAIL rstmid_reach: reached k=7 %b, want 1", found); end
        #2;
        wb_rst_ni = 1'b0;
        #1;
        total++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: cyc=%b stb=%b, want 0 0", wbm_cyc_o, wbm_stb_o);
        end
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        total++;
        if (wbm_cyc_o !== 1'b0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin
            bad++;
            $display("FAIL rstmid_bus: cyc=%b adr=%h dat=%h sel=%h, want 0 0 0 0",
                     wbm_cyc_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        total++;
        if (spike_ready_o !== 1'b1 || busy_o !== 1'b0 || frame_cnt_o !== 16'd0 ||
            err_timeout_o !== 1'b0 || done_cnt != d0) begin
            bad++;
            $display("FAIL rstmid_status: ready=%b busy=%b fcnt=%0d err=%b pulses=%0d, want 1 0 0 0 0",
                     spike_ready_o, busy_o, frame_cnt_o, err_timeout_o, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        int unsigned n0, d0, b0;
        bit          ok1, ok2, ok3;
        exp_a = 64'hDEAD_BEEF_0000_0001;
        exp_b = 64'h8421_0000_1248_0000;
        n0 = log_n; d0 = done_cnt; b0 = beats_acc;
        send_frame(64'hDEAD_BEEF_0000_0001, 64, 1'b1, ok1);
        send_frame(64'h8421_0000_1248_0000, 64, 1'b0, ok2);
        wait_done(d0 + 2, ok3);
        total++;
        if (!ok1 || !ok2 || !ok3) begin
            bad++;
            $display("FAIL b2b_progress: send1=%b send2=%b done=%b, want 1 1 1", ok1, ok2, ok3);
        end
        total++;
        if (beats_acc - b0 != 128 || done_cnt - d0 != 2 || frame_cnt_o !== 16'd2) begin
            bad++;
            $display("FAIL b2b_counts: beats=%0d pulses=%0d fcnt=%0d, want 128 2 2",
                     beats_acc - b0, done_cnt - d0, frame_cnt_o);
        end
        total++;
        if (log_n - n0 != 32) begin
            bad++;
            $display("FAIL b2b_nwrites: got %0d, want 32", log_n - n0);
        end else begin
            for (int k = 0; k < 16; k++) begin
                total++;
                if (log_adr[n0 + k] !== 32'(k) || log_dat[n0 + k] !== {28'h0, exp_a[4*k +: 4]}) begin
                    bad++;
                    $display("FAIL b2b_f1_write%0d: adr=%h dat=%h, want adr=%h dat=%h", k,
                             log_adr[n0 + k], log_dat[n0 + k], k, exp_a[4*k +: 4]);
                end
                total++;
                if (log_adr[n0 + 16 + k] !== 32'(k) || log_dat[n0 + 16 + k] !== {28'h0, exp_b[4*k +: 4]}) begin
                    bad++;
                    $display("FAIL b2b_f2_write%0d: adr=%h dat=%h, want adr=%h dat=%h", k,
                             log_adr[n0 + 16 + k], log_dat[n0 + 16 + k], k, exp_b[4*k +: 4]);
                end
            end
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL bus_rules: violations=%0d, want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_last();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
